bufplay: RTL

//  Single-clock playback buffer: host fills a dual-port RAM by random-access writes, then on start

---
 rtl/bufplay_pkg.sv | 21 ++
 rtl/bufplay_skid.sv | 46 ++++
 rtl/dpram2.sv | 71 +++++++
 rtl/bufplay.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/bufplay_pkg.sv
// Shared types and constants for the playback buffer: FSM states, skid depth,
// RAM read latency and the stream-side address width helper.
package bufplay_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int unsigned SKID_DEPTH = 4;
  localparam int unsigned RD_LAT     = 2;

  // Read-side address width given host/stream widths and host address width.
  function automatic int unsigned awr(input int unsigned dww, input int unsigned dwr,
                                      input int unsigned aww);
    if (dww > dwr) return aww + $clog2(dww / dwr);
    return aww - $clog2(dwr / dww);
  endfunction

endpackage

// File: rtl/bufplay_skid.sv
// Small synchronous FIFO that absorbs RAM returns and presents the stream head;
// head data is held steady until popped.
module bufplay_skid
  import bufplay_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = SKID_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [DW-1:0]              din_i,
  input  logic                       pop_i,
  output logic [DW-1:0]              dout_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wp_q;
  logic [PW-1:0] rp_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wp_q] <= din_i;
        wp_q        <= wp_q + PW'(1);
      end
      if (pop_i) rp_q <= rp_q + PW'(1);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign dout_o  = mem_q[rp_q];
  assign valid_o = (cnt_q != '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/dpram2.sv
// Single-clock simple dual-port RAM with independent write/read widths
// (ratio a power of two), optional input and output registers on the read port.
module dpram2 #(
  parameter int unsigned WW     = 32,
  parameter int unsigned RW     = 32,
  parameter int unsigned WAW    = 8,
  parameter int unsigned RAW    = 8,
  parameter int unsigned BUFIN  = 1,
  parameter int unsigned BUFOUT = 1,
  parameter int unsigned SIM    = 0
) (
  input  logic           clk_i,
  input  logic           we_i,
  input  logic [WAW-1:0] waddr_i,
  input  logic [WW-1:0]  wdata_i,
  input  logic           re_i,
  input  logic [RAW-1:0] raddr_i,
  output logic [RW-1:0]  rdata_o
);
  localparam int unsigned NW  = (WW < RW) ? WW : RW;
  localparam int unsigned WR  = WW / NW;
  localparam int unsigned RR  = RW / NW;
  localparam int unsigned NAW = (WAW > RAW) ? WAW : RAW;

  logic [NW-1:0]  mem [2**NAW];
  logic           re_s;
  logic [RAW-1:0] ra_s;
  logic [RW-1:0]  rd_c;

  // Storage is kept at the narrower width; lower lanes sit at lower addresses.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < int'(WR); i++) begin
        mem[NAW'(32'(waddr_i) * WR + 32'(i))] <= wdata_i[i*NW +: NW];
      end
    end
  end

  if (BUFIN != 0) begin : g_bufin
    logic           re_q;
    logic [RAW-1:0] ra_q;
    always_ff @(posedge clk_i) begin
      re_q <= re_i;
      ra_q <= raddr_i;
    end
    assign re_s = re_q;
    assign ra_s = ra_q;
  end else begin : g_nobufin
    assign re_s = re_i;
    assign ra_s = raddr_i;
  end

  always_comb begin
    rd_c = '0;
    for (int j = 0; j < int'(RR); j++) begin
      rd_c[j*NW +: NW] = mem[NAW'(32'(ra_s) * RR + 32'(j))];
    end
  end

  // In simulation builds the output only moves on real reads, which keeps traces readable.
  if (BUFOUT != 0) begin : g_bufout
    logic [RW-1:0] rdata_q;
    always_ff @(posedge clk_i) begin
      if (re_s || (SIM == 0)) rdata_q <= rd_c;
    end
    assign rdata_o = rdata_q;
  end else begin : g_nobufout
    assign rdata_o = rd_c;
  end

endmodule

// File: rtl/bufplay.sv
// Playback buffer: host loads RAM by random-access writes, then start streams
// len words sequentially (optionally looping) on a valid/ready port.
module bufplay
  import bufplay_pkg::*;
#(
  parameter int unsigned DWW = 8,
  parameter int unsigned DWR = 32,
  parameter int unsigned AWW = 8,
  parameter int unsigned SIM = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DWW-1:0]            wdata,
  input  logic [AWW-1:0]            waddr,
  input  logic                      wen,
  input  logic [awr(DWW,DWR,AWW):0] len,
  input  logic                      loop,
  input  logic                      start,
  input  logic                      stop,
  output logic [DWR-1:0]            sdata,
  output logic                      svalid,
  input  logic                      sready,
  output logic                      busy,
  output logic                      done,
  output logic                      wr_err
);
  localparam int unsigned AWR = awr(DWW, DWR, AWW);
  localparam int unsigned LW  = AWR + 1;
  localparam int unsigned CW  = $clog2(SKID_DEPTH + 1);
  localparam int unsigned SW  = CW + 1;

  state_e           state_q, state_d;
  logic [AWR-1:0]   raddr_q, raddr_d;
  logic [LW-1:0]    len_q, len_d;
  logic             loop_q, loop_d;
  logic [CW-1:0]    inflt_q;
  logic [RD_LAT-1:0] rv_q;
  logic             busy_q, done_q, done_d, wr_err_q, wr_err_d;
  logic             wen_q;
  logic [AWW-1:0]   waddr_q;
  logic [DWW-1:0]   wdata_q;

  logic             ren_c;
  logic [AWR-1:0]   rd_addr_c;
  logic [LW-1:0]    len_sat_c;
  logic             credit_c, last_c, push_c, pop_c, drained_c;
  logic [CW-1:0]    fifo_cnt;
  logic [DWR-1:0]   ram_rdata;

  assign len_sat_c = (len[AWR] && (len[AWR-1:0] != '0)) ? {1'b1, {AWR{1'b0}}} : len;
  // Outstanding reads plus buffered words may never exceed the skid capacity.
  assign credit_c  = ({1'b0, inflt_q} + {1'b0, fifo_cnt}) < SW'(SKID_DEPTH);
  assign last_c    = ({1'b0, raddr_q} == (len_q - LW'(1)));
  assign push_c    = rv_q[RD_LAT-1];
  assign pop_c     = svalid & sready;
  assign drained_c = (inflt_q == '0) &&
                     ((fifo_cnt == '0) || ((fifo_cnt == CW'(1)) && pop_c));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      raddr_q  <= '0;
      len_q    <= '0;
      loop_q   <= 1'b0;
      inflt_q  <= '0;
      rv_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      raddr_q  <= raddr_d;
      len_q    <= len_d;
      loop_q   <= loop_d;
      inflt_q  <= inflt_q + CW'(ren_c) - CW'(push_c);
      rv_q     <= {rv_q[RD_LAT-2:0], ren_c};
      busy_q   <= (state_d != IDLE);
      done_q   <= done_d;
      wr_err_q <= wr_err_d;
      wen_q    <= wen & ~busy_q;
      waddr_q  <= waddr;
      wdata_q  <= wdata;
    end
  end

  // The first read is issued in the start cycle itself to reach first data at start+3.
  always_comb begin
    state_d   = state_q;
    raddr_d   = raddr_q;
    len_d     = len_q;
    loop_d    = loop_q;
    ren_c     = 1'b0;
    rd_addr_c = raddr_q;
    done_d    = 1'b0;
    wr_err_d  = wr_err_q | (wen & busy_q);
    case (state_q)
      IDLE: begin
        rd_addr_c = '0;
        if (start) begin
          wr_err_d = 1'b0;
          len_d    = len_sat_c;
          loop_d   = loop;
          if (len_sat_c == '0) begin
            done_d = 1'b1;
          end else begin
            ren_c = 1'b1;
            if (len_sat_c == LW'(1)) begin
              raddr_d = '0;
              state_d = loop ? RUN : DRAIN;
            end else begin
              raddr_d = AWR'(1);
              state_d = RUN;
            end
          end
        end
      end
      RUN: begin
        if (stop) begin
          state_d = DRAIN;
        end else if (credit_c) begin
          ren_c = 1'b1;
          if (last_c) begin
            raddr_d = '0;
            if (!loop_q) state_d = DRAIN;
          end else begin
            raddr_d = raddr_q + AWR'(1);
          end
        end
      end
      DRAIN: begin
        if (drained_c) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  dpram2 #(
    .WW(DWW), .RW(DWR), .WAW(AWW), .RAW(AWR), .BUFIN(1), .BUFOUT(1), .SIM(SIM)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (wen_q),
    .waddr_i(waddr_q),
    .wdata_i(wdata_q),
    .re_i   (ren_c),
    .raddr_i(rd_addr_c),
    .rdata_o(ram_rdata)
  );

  bufplay_skid #(
    .DW(DWR), .DEPTH(SKID_DEPTH)
  ) u_skid (
    .clk    (clk),
    .reset  (reset),
    .push_i (push_c),
    .din_i  (ram_rdata),
    .pop_i  (pop_c),
    .dout_o (sdata),
    .valid_o(svalid),
    .count_o(fifo_cnt)
  );

  assign busy   = busy_q;
  assign done   = done_q;
  assign wr_err = wr_err_q;

endmodule
